// File: rtl/iob_native_mem_resp_if.sv
// IOb native memory bus: request channel from the master, read-data/ready back from the responder.
// Member names keep the responder-side port names so traces line up with the block's pinout.
interface iob_native_mem_resp_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                iob_avalid_i;
    logic [ADDR_W-1:0]   iob_addr_i;
    logic [DATA_W-1:0]   iob_wdata_i;
    logic [DATA_W/8-1:0] iob_wstrb_i;
    logic [DATA_W-1:0]   iob_rdata_o;
    logic                iob_rvalid_o;
    logic                iob_ready_o;

    modport master (
        output iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        input  iob_rdata_o, iob_rvalid_o, iob_ready_o
    );

    modport slave (
        input  iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        output iob_rdata_o, iob_rvalid_o, iob_ready_o
    );
endinterface

// File: rtl/iob_native_mem_resp.sv
// Word-addressed RAM responder on the IOb native bus with byte strobes and
// a configurable number of stall cycles per access.
module iob_native_mem_resp #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cke_i,
    iob_native_mem_resp_if.slave iob
);
    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 2 ** WORD_W;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                do_access;
    logic                acc_write;
    logic [WORD_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;
    logic                unused_addr_lsb;

    // Byte offset within the word plays no part in word-wide accesses.
    assign unused_addr_lsb = ^iob.iob_addr_i[1:0];

    assign accept = cke_i & iob.iob_avalid_i & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        do_access = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;

        if (WAIT_CYCLES == 0) begin
            // Zero-wait: the access happens at the acceptance edge straight from the bus.
            do_access = accept;
            acc_addr  = iob.iob_addr_i[ADDR_W-1:2];
            acc_wdata = iob.iob_wdata_i;
            acc_wstrb = iob.iob_wstrb_i;
        end else if (cke_i) begin
            unique case (state_q)
                IDLE: begin
                    if (iob.iob_avalid_i) begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                        addr_d  = iob.iob_addr_i[ADDR_W-1:2];
                        wdata_d = iob.iob_wdata_i;
                        wstrb_d = iob.iob_wstrb_i;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - 4'd1;
                    // The edge that takes the counter to zero performs the stored access.
                    if (cnt_q == 4'd1) begin
                        state_d   = IDLE;
                        do_access = 1'b1;
                    end
                end
            endcase
        end

        acc_write = |acc_wstrb;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        if (cke_i) begin
            rvalid_d = do_access & ~acc_write;
            if (do_access && !acc_write) rdata_d = mem[acc_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Reset aborts any access due on the same edge; contents themselves survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_access && acc_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (acc_wstrb[b]) mem[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
        end
    end

    assign iob.iob_ready_o  = (state_q == IDLE);
    assign iob.iob_rdata_o  = rdata_q;
    assign iob.iob_rvalid_o = rvalid_q;
endmodule
